pulse_stretch_mc: RTL and testbench
===================================

Name: pulse_stretch_mc

Overview:
- Multi-channel, parametrised successor to the single-strobe fast-to-slow pulse crossing.
- Sits in the source (fast) clock domain and converts short strobes into stretched pulses with a guaranteed low gap, so a slower domain can sample every event.
- Adds per-channel queuing of strobes that arrive while a pulse is in flight, a saturating pending count, and a sticky overflow flag.

Parameters:
- CHANNELS, 4, number of independent strobe channels.
- STRETCH, 3, high time of each output pulse in clk_in cycles (≥1).
- GAP, 2, minimum low time between consecutive output pulses on one channel (≥1).
- PEND_W, 2, width of the per-channel pending counter; maximum is 2^PEND_W-1.

Ports:
- clk_in  input  1  single clock, source domain.
- rst_n_in  input  1  asynchronous active-low reset.
- strobe_in  input  CHANNELS  level strobes; each rising edge is one event.
- clear_in  input  1  single-cycle pulse; clears all overflow flags.
- strobe_out  output  CHANNELS  stretched pulses, registered.
- busy_out  output  CHANNELS  channel is in HIGH or GAP, or has pending > 0.
- overflow_out  output  CHANNELS  sticky flag: an event was dropped.

Behaviour:
- Reset (asynchronous, while rst_n_in=0):
  - strobe_out, busy_out, overflow_out = 0.
  - All pending counts = 0; all FSMs in IDLE.
  - Edge-detect history = all ones, so a strobe already high at reset release produces no event.
- Event detection: event on channel i at edge t if strobe_in[i]=1 and the registered history bit is 0. A strobe held high for any length is one event.
- Per-channel FSM (IDLE, HIGH, GAP), with one down-counter sized $clog2(max(STRETCH,GAP)+1):
  - IDLE: on an event, go to HIGH next cycle. Latency is 1 cycle: an event sampled at edge t gives strobe_out high from cycle t+1.
  - HIGH: strobe_out=1 for exactly STRETCH cycles, then GAP.
  - GAP: strobe_out=0 for exactly GAP cycles. On the last GAP cycle, if pending>0, go to HIGH and decrement pending; otherwise go to IDLE.
- Pending count:
  - An event while in HIGH or GAP increments pending.
  - An event while pending is at maximum is dropped and sets overflow_out[i]; pending stays at maximum.
  - An event on the same edge as a GAP-end decrement leaves pending unchanged and is never counted as overflow.
- Overflow: stays set until a clear_in pulse. If clear_in and a new drop occur on the same edge, the set wins.
- busy_out[i] = (state != IDLE) || (pending != 0), registered with the state.
- Channels are fully independent; simultaneous events on several channels are all accepted.
- Reset asserted mid-pulse: outputs drop immediately (asynchronous). No queued pulse is replayed after release.
- Steady-state maximum throughput per channel is one event per STRETCH+GAP cycles; faster sustained input must eventually overflow.

Decomposition:
- Package pulse_stretch_pkg:
  - State enum (IDLE, HIGH, GAP).
  - Localparam function for the counter width.
  - Parameter-legality checks (STRETCH≥1, GAP≥1, PEND_W≥1).
- Sub-module pulse_stretch_ch holds one channel: edge detect, FSM, counters, overflow flag.
- The top level generates CHANNELS instances and fans clear_in to all of them.

Test Plan (CHANNELS=4, STRETCH=3, GAP=2, PEND_W=2; cycle N = Nth rising edge after reset release):
- Reset with strobe_in=4'hF held through release → all outputs 0; no pulses for 20 cycles.
- strobe_in[0] 0→1 sampled at cycle 5, held high 10 cycles → strobe_out[0] high cycles 6–8 only; busy_out[0] high cycles 6–10.
- Single-cycle strobes on channel 1 at cycles 5, 7, 9 → strobe_out[1] high at 6–8, 11–13, 16–18; busy_out[1] falls after cycle 20.
- Channel 2 strobes at odd cycles 5–17 (7 events) → 6 pulses (6–8, 11–13, 16–18, 21–23, 26–28, 31–33); overflow_out[2]=1 from cycle 18; clear_in at cycle 40 → overflow_out[2]=0 from cycle 41.
- Simultaneous strobes on all channels at cycle 5 → all strobe_out bits high 6–8 in lockstep; overflow_out stays 0.
- rst_n_in low at cycle 7 (mid-pulse, pending=1 on channel 1) → strobe_out, busy_out, overflow_out 0 immediately; after release, no pulse until a new strobe edge.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretch_pkg
//
// Shared definitions for the multi-channel pulse stretcher:
//   - ps_state_t     : per-channel FSM state encoding (IDLE, HIGH, GAP)
//   - ps_cnt_width() : width of the shared HIGH/GAP down-counter
//   - ps_params_ok() : legality test for the stretcher parameters
// -----------------------------------------------------------------------------
package pulse_stretch_pkg;

    // The S_ prefix keeps the enum literals clear of the GAP parameter name.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } ps_state_t;

    // A single counter times both phases, so it is sized for the longer one.
    function automatic int ps_cnt_width(input int stretch, input int gap);
        int longest;
        longest = (stretch > gap) ? stretch : gap;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

    function automatic bit ps_params_ok(input int stretch, input int gap,
                                        input int pend_w);
        return (stretch >= 1) && (gap >= 1) && (pend_w >= 1);
    endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// -----------------------------------------------------------------------------
// pulse_stretch_ch
//
// One channel of the pulse stretcher. Turns rising edges on a level strobe
// into pulses exactly STRETCH cycles high, separated by at least GAP low
// cycles. Edges that arrive while a pulse is in flight are queued in a
// saturating pending counter; an edge that finds the counter full is dropped
// and raises a sticky overflow flag.
//
// Ports:
//   clk       in   source-domain clock
//   rst_n     in   asynchronous active-low reset
//   strobe    in   level strobe; each rising edge is one event
//   clear     in   single-cycle pulse clearing the overflow flag
//   pulse     out  registered stretched pulse
//   busy      out  registered: FSM not idle, or events still queued
//   overflow  out  registered sticky drop flag
// -----------------------------------------------------------------------------
module pulse_stretch_ch
    import pulse_stretch_pkg::*;
#(
    parameter int STRETCH = 3,
    parameter int GAP     = 2,
    parameter int PEND_W  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic clear,
    output logic pulse,
    output logic busy,
    output logic overflow
);

    localparam int CNT_W = ps_cnt_width(STRETCH, GAP);

    // Counters load "length - 1" and the phase ends on the cycle they read 0.
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    ps_state_t         state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [PEND_W-1:0] pend, pend_nx;
    logic              hist;
    logic              ovf_nx;
    logic              evt;
    logic              cnt_zero;
    logic              gap_end;
    logic              drop;

    assign evt      = strobe & ~hist;
    assign cnt_zero = (cnt == '0);
    assign gap_end  = (state == S_GAP) && cnt_zero;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        ovf_nx   = overflow;
        drop     = 1'b0;

        case (state)
            S_IDLE: begin
                if (evt) begin
                    state_nx = S_HIGH;
                    cnt_nx   = HIGH_LOAD;
                end
            end
            S_HIGH: begin
                if (cnt_zero) begin
                    state_nx = S_GAP;
                    cnt_nx   = GAP_LOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_GAP: begin
                // An edge landing exactly on the last gap cycle with nothing
                // queued is served straight away instead of being queued;
                // otherwise it would sit in pend with the FSM parked in IDLE.
                if (cnt_zero) begin
                    if ((pend != '0) || evt) begin
                        state_nx = S_HIGH;
                        cnt_nx   = HIGH_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

        // On a gap-end edge a new event replaces the one being launched, so
        // the queue depth is unchanged and nothing can be dropped.
        if (gap_end) begin
            if (!evt && (pend != '0)) begin
                pend_nx = pend - 1'b1;
            end
        end else if (evt && (state != S_IDLE)) begin
            if (pend == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_nx = pend + 1'b1;
            end
        end

        // A drop on the same edge as clear must stay visible.
        if (clear) begin
            ovf_nx = 1'b0;
        end
        if (drop) begin
            ovf_nx = 1'b1;
        end
    end

    // History resets to one so a strobe already high at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= 1'b1;
            state    <= S_IDLE;
            cnt      <= '0;
            pend     <= '0;
            pulse    <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            hist     <= strobe;
            state    <= state_nx;
            cnt      <= cnt_nx;
            pend     <= pend_nx;
            pulse    <= (state_nx == S_HIGH);
            busy     <= (state_nx != S_IDLE) || (pend_nx != '0);
            overflow <= ovf_nx;
        end
    end

endmodule

// File: rtl/pulse_stretch_mc.sv
// -----------------------------------------------------------------------------
// pulse_stretch_mc
//
// Multi-channel fast-to-slow pulse stretcher. Each channel converts strobe
// edges into pulses STRETCH cycles wide with at least GAP low cycles between
// them, so a slower clock domain can sample every event. Channels are fully
// independent; clear_in is shared by all of them.
//
// Ports:
//   clk_in        in   [1]         source-domain clock
//   rst_n_in      in   [1]         asynchronous active-low reset
//   strobe_in     in   [CHANNELS]  level strobes, one event per rising edge
//   clear_in      in   [1]         single-cycle pulse, clears all overflow flags
//   strobe_out    out  [CHANNELS]  registered stretched pulses
//   busy_out      out  [CHANNELS]  channel active or holding queued events
//   overflow_out  out  [CHANNELS]  sticky: an event was dropped on the channel
// -----------------------------------------------------------------------------
module pulse_stretch_mc
    import pulse_stretch_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int STRETCH  = 3,
    parameter int GAP      = 2,
    parameter int PEND_W   = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [CHANNELS-1:0] strobe_in,
    input  logic                clear_in,
    output logic [CHANNELS-1:0] strobe_out,
    output logic [CHANNELS-1:0] busy_out,
    output logic [CHANNELS-1:0] overflow_out
);

    if (!ps_params_ok(STRETCH, GAP, PEND_W) || (CHANNELS < 1)) begin : g_bad_params
        $error("pulse_stretch_mc: need CHANNELS>=1, STRETCH>=1, GAP>=1, PEND_W>=1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_stretch_ch #(
            .STRETCH (STRETCH),
            .GAP     (GAP),
            .PEND_W  (PEND_W)
        ) u_ch (
            .clk      (clk_in),
            .rst_n    (rst_n_in),
            .strobe   (strobe_in[i]),
            .clear    (clear_in),
            .pulse    (strobe_out[i]),
            .busy     (busy_out[i]),
            .overflow (overflow_out[i])
        );
    end

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch_mc
//
// Directed bench for pulse_stretch_mc (CHANNELS=4, STRETCH=3, GAP=2, PEND_W=2).
// Edge N is the Nth rising clock edge after reset release; the value sampled
// just after edge N is what the expectations call cycle N+1.
// -----------------------------------------------------------------------------
module tb_pulse_stretch_mc;

    logic       clk_in;
    logic       rst_n_in;
    logic [3:0] strobe_in;
    logic       clear_in;
    logic [3:0] strobe_out;
    logic [3:0] busy_out;
    logic [3:0] overflow_out;

    int checks;
    int errors;
    int edge_n;
    int oc;

    pulse_stretch_mc #(
        .CHANNELS (4),
        .STRETCH  (3),
        .GAP      (2),
        .PEND_W   (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .strobe_in    (strobe_in),
        .clear_in     (clear_in),
        .strobe_out   (strobe_out),
        .busy_out     (busy_out),
        .overflow_out (overflow_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic win(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, edge_n + 1, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        edge_n++;
        oc = edge_n + 1;
    endtask

    task automatic do_reset(input logic [3:0] s);
        rst_n_in  = 1'b0;
        strobe_in = s;
        clear_in  = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        edge_n   = 0;
        oc       = 1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        edge_n    = 0;
        oc        = 0;
        rst_n_in  = 1'b0;
        strobe_in = 4'h0;
        clear_in  = 1'b0;

        // Strobes held high through reset release: no events at all.
        do_reset(4'hF);
        chk("rst_out", strobe_out, 4'h0);
        chk("rst_busy", busy_out, 4'h0);
        chk("rst_ovf", overflow_out, 4'h0);
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("held_out", strobe_out, 4'h0);
            chk("held_busy", busy_out, 4'h0);
            chk("held_ovf", overflow_out, 4'h0);
        end

        // Channel 0 held high for 10 cycles: a single pulse.
        do_reset(4'h0);
        for (int e = 1; e <= 20; e++) begin
            strobe_in = (e >= 5 && e <= 14) ? 4'b0001 : 4'b0000;
            tick();
            chk("long_out", strobe_out, {3'b000, win(oc, 6, 8)});
            chk("long_busy", busy_out, {3'b000, win(oc, 6, 10)});
        end

        // Channel 1: three short strobes, two of them queued.
        do_reset(4'h0);
        for (int e = 1; e <= 24; e++) begin
            strobe_in = (e == 5 || e == 7 || e == 9) ? 4'b0010 : 4'b0000;
            tick();
            chk("queue_out", strobe_out,
                {2'b00, win(oc, 6, 8) | win(oc, 11, 13) | win(oc, 16, 18), 1'b0});
            chk("queue_busy", busy_out, {2'b00, win(oc, 6, 20), 1'b0});
        end

        // Channel 2: seven fast events, one dropped; clear collides with the
        // drop at edge 17 (set wins) and clears cleanly at edge 40.
        do_reset(4'h0);
        for (int e = 1; e <= 45; e++) begin
            strobe_in = (e >= 5 && e <= 17 && (e % 2) == 1) ? 4'b0100 : 4'b0000;
            clear_in  = (e == 17 || e == 40);
            tick();
            chk("ovf_out", strobe_out,
                {1'b0, win(oc, 6, 8) | win(oc, 11, 13) | win(oc, 16, 18) |
                       win(oc, 21, 23) | win(oc, 26, 28) | win(oc, 31, 33), 2'b00});
            chk("ovf_busy", busy_out, {1'b0, win(oc, 6, 35), 2'b00});
            chk("ovf_flag", overflow_out, {1'b0, win(oc, 18, 40), 2'b00});
        end
        clear_in = 1'b0;

        // All channels strobed together.
        do_reset(4'h0);
        for (int e = 1; e <= 14; e++) begin
            strobe_in = (e == 5) ? 4'hF : 4'h0;
            tick();
            chk("all_out", strobe_out, win(oc, 6, 8) ? 4'hF : 4'h0);
            chk("all_busy", busy_out, win(oc, 6, 10) ? 4'hF : 4'h0);
            chk("all_ovf", overflow_out, 4'h0);
        end

        // Reset mid-pulse with one event queued on channel 1.
        do_reset(4'h0);
        for (int e = 1; e <= 6; e++) begin
            strobe_in = (e == 4 || e == 6) ? 4'b0010 : 4'b0000;
            tick();
        end
        chk("pre_rst_out", strobe_out, 4'b0010);
        chk("pre_rst_busy", busy_out, 4'b0010);
        strobe_in = 4'b0010;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_out", strobe_out, 4'h0);
        chk("mid_rst_busy", busy_out, 4'h0);
        chk("mid_rst_ovf", overflow_out, 4'h0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        edge_n   = 0;
        for (int e = 1; e <= 18; e++) begin
            strobe_in = (e == 11) ? 4'b0000 : 4'b0010;
            tick();
            chk("post_rst_out", strobe_out, {2'b00, win(oc, 13, 15), 1'b0});
            chk("post_rst_busy", busy_out, {2'b00, win(oc, 13, 17), 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
